// File: rtl/gcm_pkg.sv
// Shared types, constants and helper functions for the GCM datapath blocks.
package gcm_pkg;

    localparam int BLOCK_W = 128;
    localparam int BYTES_W = 5;
    localparam int ENTRY_W = BLOCK_W + 1 + BYTES_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        DRAIN = ST_DRAIN
    } gctr_state_e;

    typedef struct packed {
        logic [BLOCK_W-1:0] data;
        logic               last;
        logic [BYTES_W-1:0] nbytes;
    } gctr_entry_t;

    // inc_s: increment the low s bits modulo 2^s, upper bits untouched.
    function automatic logic [BLOCK_W-1:0] inc_ctr(input logic [BLOCK_W-1:0] cb, input int s);
        logic [BLOCK_W-1:0] mask;
        if (s >= BLOCK_W) begin
            mask = {BLOCK_W{1'b1}};
        end else if (s <= 0) begin
            mask = {BLOCK_W{1'b0}};
        end else begin
            mask = (BLOCK_W'(1) << s) - BLOCK_W'(1);
        end
        return (cb & ~mask) | ((cb + BLOCK_W'(1)) & mask);
    endfunction

    // A byte count of 0 or above 16 means a full block.
    function automatic logic [BYTES_W-1:0] norm_bytes(input logic [BYTES_W-1:0] nbytes);
        if ((nbytes == 5'd0) || (nbytes > 5'd16)) begin
            return 5'd16;
        end else begin
            return nbytes;
        end
    endfunction

    function automatic logic [BLOCK_W-1:0] byte_mask(input logic [BYTES_W-1:0] nbytes);
        logic [BYTES_W-1:0] n;
        n = norm_bytes(nbytes);
        return ~({BLOCK_W{1'b1}} >> {n, 3'b000});
    endfunction

endpackage

// File: rtl/gctr_fifo.sv
// Small synchronous FIFO with registered storage; push when full and pop when
// empty are ignored so the pointers can never corrupt.
module gctr_fifo
    import gcm_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;
    assign head_o    = mem_q[rd_ptr_q[AW-1:0]];

    // Storage and pointer update
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/gctr_stream.sv
// Streaming GCTR engine: issues counter blocks to a shared cipher core and
// XORs the in-order keystream onto buffered input blocks.
module gctr_stream
    import gcm_pkg::*;
#(
    parameter int INC_WIDTH = 32,
    parameter int DEPTH     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BLOCK_W-1:0] icb_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic               in_last,
    input  logic [BYTES_W-1:0] in_bytes,
    output logic               cb_valid,
    input  logic               cb_ready,
    output logic [BLOCK_W-1:0] cb_out,
    input  logic               ks_valid,
    input  logic [BLOCK_W-1:0] ks_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               out_last,
    output logic [BYTES_W-1:0] out_bytes,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] OCC_MAX = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] OCC_ONE = CNT_W'(1);

    gctr_state_e        state_q, state_d;
    logic [BLOCK_W-1:0] cb_q, cb_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               room_s;
    logic               issue_s;
    logic               ks_take_s;
    logic               ks_spur_s;
    logic               out_pop_s;
    gctr_entry_t        pend_push_s, pend_head_s;
    gctr_entry_t        res_push_s, res_head_s;
    logic               pend_full_s, pend_empty_s;
    logic               res_full_s, res_empty_s;

    // Occupancy covers both FIFOs, so keystream (which cannot stall) always has room.
    assign room_s    = (occ_q < OCC_MAX) & ~pend_full_s & ~res_full_s;
    assign in_ready  = (state_q == RUN) & cb_ready & room_s;
    assign cb_valid  = (state_q == RUN) & in_valid & room_s;
    assign issue_s   = cb_valid & cb_ready;
    assign cb_out    = cb_q;
    assign ks_take_s = ks_valid & ~pend_empty_s;
    assign ks_spur_s = ks_valid & pend_empty_s;
    assign out_valid = ~res_empty_s;
    assign out_pop_s = out_valid & out_ready;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;

    // Build FIFO entries for the issue and keystream paths
    always_comb begin
        pend_push_s.data   = in_data;
        pend_push_s.last   = in_last;
        pend_push_s.nbytes = 5'd16;
        if (in_last) begin
            pend_push_s.nbytes = norm_bytes(in_bytes);
        end else begin
            pend_push_s.nbytes = 5'd16;
        end
        res_push_s.data   = (pend_head_s.data ^ ks_data) & byte_mask(pend_head_s.nbytes);
        res_push_s.last   = pend_head_s.last;
        res_push_s.nbytes = pend_head_s.nbytes;
    end

    gctr_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_pend_fifo (
        .clk_i      (clk),
        .rst_ni     (rst),
        .push_i     (issue_s),
        .push_data_i(pend_push_s),
        .pop_i      (ks_take_s),
        .full_o     (pend_full_s),
        .empty_o    (pend_empty_s),
        .head_o     (pend_head_s)
    );

    gctr_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_res_fifo (
        .clk_i      (clk),
        .rst_ni     (rst),
        .push_i     (ks_take_s),
        .push_data_i(res_push_s),
        .pop_i      (out_pop_s),
        .full_o     (res_full_s),
        .empty_o    (res_empty_s),
        .head_o     (res_head_s)
    );

    // Present the result head; blank fields while nothing is waiting
    always_comb begin
        out_data  = {BLOCK_W{1'b0}};
        out_last  = 1'b0;
        out_bytes = {BYTES_W{1'b0}};
        if (!res_empty_s) begin
            out_data  = res_head_s.data;
            out_last  = res_head_s.last;
            out_bytes = res_head_s.nbytes;
        end else begin
            out_data  = {BLOCK_W{1'b0}};
            out_last  = 1'b0;
            out_bytes = {BYTES_W{1'b0}};
        end
    end

    // Occupancy: +1 per issue, -1 per delivered result
    always_comb begin
        occ_d = occ_q;
        case ({issue_s, out_pop_s})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    // FSM next state, counter block advance and status flags
    always_comb begin
        state_d = state_q;
        cb_d    = cb_q;
        done_d  = 1'b0;
        err_d   = err_q | ks_spur_s;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cb_d    = icb_in;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (issue_s) begin
                    cb_d = inc_ctr(cb_q, INC_WIDTH);
                    if (in_last) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (out_pop_s && res_head_s.last && (occ_q == OCC_ONE)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cb_q    <= {BLOCK_W{1'b0}};
            occ_q   <= {CNT_W{1'b0}};
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cb_q    <= cb_d;
            occ_q   <= occ_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_gctr_stream.sv
// Directed bench for gctr_stream with a latency-configurable cipher model and
// an expected-result scoreboard.
module tb_gctr_stream;
    localparam logic [127:0] KS_K = {16{8'hA5}};

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] icb_in;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_last;
    logic [4:0]   in_bytes;
    logic         cb_valid;
    logic         cb_ready;
    logic [127:0] cb_out;
    logic         ks_valid;
    logic [127:0] ks_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;
    logic [4:0]   out_bytes;
    logic         busy;
    logic         done;
    logic         err;

    always #5 clk = ~clk;

    gctr_stream #(.INC_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .icb_in(icb_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_bytes(in_bytes),
        .cb_valid(cb_valid), .cb_ready(cb_ready), .cb_out(cb_out),
        .ks_valid(ks_valid), .ks_data(ks_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_bytes(out_bytes),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [127:0] data;
        logic         last;
        logic [4:0]   nb;
    } exp_t;

    typedef struct {
        logic [127:0] ks;
        int           due;
    } ks_t;

    exp_t         sb[$];
    ks_t          cq[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           lat = 3;
    int           spur_n = 0;
    logic [127:0] exp_cb;
    logic         done_exp;
    int           msg_n;
    int           blk_sent;
    logic [4:0]   msg_lastb;
    logic [127:0] msg_base;
    logic         msg_vary;
    logic         acc_main;

    function automatic logic [127:0] bit128(input logic x);
        return {127'd0, x};
    endfunction

    function automatic logic [127:0] exp_mask(input int nb);
        logic [127:0] m;
        m = '0;
        for (int k = 0; k < 16; k++) begin
            if (k < nb) m[127-8*k -: 8] = 8'hFF;
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: sample just before the edge, then drive cipher response at negedge.
    task automatic step(output logic acc);
        int   nb;
        exp_t e;
        ks_t  k;
        acc = 1'b0;
        #4;
        if (rst) begin
            if (in_valid && in_ready) begin
                acc = 1'b1;
                check("cb_out", cb_out, exp_cb);
                nb = (in_last && in_bytes != 5'd0 && in_bytes < 5'd16) ? int'(in_bytes) : 16;
                e.data = (in_data ^ exp_cb ^ KS_K) & exp_mask(nb);
                e.last = in_last;
                e.nb   = 5'(nb);
                sb.push_back(e);
                k.ks  = cb_out ^ KS_K;
                k.due = cyc + lat;
                cq.push_back(k);
                exp_cb = {exp_cb[127:32], exp_cb[31:0] + 32'd1};
            end
            check("done", bit128(done), bit128(done_exp));
            done_exp = 1'b0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("out_unexpected", 128'(sb.size()), 128'd1);
                end else begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", bit128(out_last), bit128(e.last));
                    check("out_bytes", {123'd0, out_bytes}, {123'd0, e.nb});
                    if (e.last) done_exp = 1'b1;
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (cq.size() > 0 && cq[0].due <= cyc) begin
            ks_valid = 1'b1;
            ks_data  = cq[0].ks;
            void'(cq.pop_front());
        end else if (spur_n > 0) begin
            ks_valid = 1'b1;
            ks_data  = {$urandom, $urandom, $urandom, $urandom};
            spur_n--;
        end else begin
            ks_valid = 1'b0;
            ks_data  = '0;
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", bit128(in_ready), bit128(1'b0));
        check("rst_cb_valid", bit128(cb_valid), bit128(1'b0));
        check("rst_out_valid", bit128(out_valid), bit128(1'b0));
        check("rst_out_last", bit128(out_last), bit128(1'b0));
        check("rst_busy", bit128(busy), bit128(1'b0));
        check("rst_done", bit128(done), bit128(1'b0));
        check("rst_err", bit128(err), bit128(1'b0));
        check("rst_out_data", out_data, 128'd0);
        check("rst_out_bytes", {123'd0, out_bytes}, 128'd0);
        check("rst_cb_out", cb_out, 128'd0);
    endtask

    // Called at a negedge: assert reset asynchronously, check, release at next negedge.
    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
        ks_valid = 1'b0; ks_data = '0; out_ready = 1'b1;
        #1;
        check_reset_outputs();
        sb.delete();
        cq.delete();
        done_exp = 1'b0;
        spur_n = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic begin_msg(input logic [127:0] icb, input int n, input logic [4:0] lb,
                             input logic [127:0] base, input logic vary);
        logic acc;
        msg_n = n; blk_sent = 0; msg_lastb = lb; msg_base = base; msg_vary = vary;
        start = 1'b1; icb_in = icb;
        in_valid = 1'b1; in_data = base; in_last = 1'b0; in_bytes = 5'd0;
        step(acc);
        check("idle_no_accept", bit128(acc), bit128(1'b0));
        start = 1'b0; in_valid = 1'b0;
        exp_cb = icb;
        check("busy_run", bit128(busy), bit128(1'b1));
    endtask

    task automatic feed(input int stop_at, input int max_cyc);
        logic        acc;
        logic [31:0] iw;
        int          n;
        n = 0;
        while (blk_sent < stop_at && n < max_cyc) begin
            iw       = blk_sent;
            in_valid = 1'b1;
            in_data  = msg_vary ? (msg_base ^ {4{iw}}) : msg_base;
            in_last  = (blk_sent == msg_n - 1);
            in_bytes = in_last ? msg_lastb : 5'd3;
            step(acc);
            if (acc) blk_sent++;
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        logic acc;
        int   n;
        n = 0;
        while (!done_exp && n < max_cyc) begin
            step(acc);
            n++;
        end
        check("drain_last_seen", bit128(done_exp), bit128(1'b1));
        step(acc);
        check("idle_after_done", bit128(busy), bit128(1'b0));
        check("sb_drained", 128'(sb.size()), 128'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; icb_in = '0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; in_bytes = 5'd0; cb_ready = 1'b1; ks_valid = 1'b0;
        ks_data = '0; out_ready = 1'b1; done_exp = 1'b0; exp_cb = '0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b1;

        // Three full zero blocks from icb=1, cipher latency 3
        lat = 3;
        begin_msg(128'd1, 3, 5'd0, 128'd0, 1'b0);
        feed(3, 60);
        check("basic_count", 128'(blk_sent), 128'd3);
        wait_done(100);
        check("basic_err", bit128(err), bit128(1'b0));

        // Counter wrap in the low 32 bits
        begin_msg(128'h11223344_55667788_99AABBCC_FFFFFFFF, 2, 5'd0,
                  128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1);
        feed(2, 60);
        check("wrap_count", 128'(blk_sent), 128'd2);
        wait_done(100);
        check("wrap_cb_final", cb_out, 128'h11223344_55667788_99AABBCC_00000001);

        // Partial final block of 5 bytes, data all ones
        begin_msg(128'hCAFEBABE_00000000_DEADBEEF_00000010, 2, 5'd5, {128{1'b1}}, 1'b0);
        feed(2, 60);
        wait_done(100);

        // Single-block messages at byte-count boundaries (0 and 20 mean 16; 1 is minimum)
        begin_msg(128'h5, 1, 5'd0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0);
        feed(1, 30);
        wait_done(100);
        begin_msg(128'h9, 1, 5'd20, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 1'b0);
        feed(1, 30);
        wait_done(100);
        begin_msg(128'hFFFFFFFE, 1, 5'd1, {128{1'b1}}, 1'b0);
        feed(1, 30);
        wait_done(100);

        // Output backpressure: only DEPTH blocks may be in flight
        lat = 1;
        out_ready = 1'b0;
        begin_msg(128'h7700_0000_0000_0000_0000_0000_0000_0100, 10, 5'd16,
                  128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0, 1'b1);
        feed(10, 15);
        check("bp_accepted", 128'(blk_sent), 128'd4);
        check("bp_in_ready", bit128(in_ready), bit128(1'b0));
        check("bp_out_valid", bit128(out_valid), bit128(1'b1));
        out_ready = 1'b1;
        feed(10, 300);
        check("bp_total", 128'(blk_sent), 128'd10);
        wait_done(100);

        // Spurious keystream while idle
        spur_n = 1;
        repeat (4) step(acc_main);
        check("spur_err", bit128(err), bit128(1'b1));
        check("spur_no_out", bit128(out_valid), bit128(1'b0));
        repeat (3) step(acc_main);
        check("spur_err_sticky", bit128(err), bit128(1'b1));

        // start during RUN is ignored
        lat = 2;
        begin_msg(128'hA000_0000_0000_0000_0000_0000_0000_0040, 4, 5'd9,
                  128'h1357_9BDF_0246_8ACE_1357_9BDF_0246_8ACE, 1'b1);
        feed(2, 40);
        start = 1'b1;
        icb_in = 128'hB000_0000_0000_0000_0000_0000_0000_0900;
        step(acc_main);
        start = 1'b0;
        check("run_start_busy", bit128(busy), bit128(1'b1));
        feed(4, 60);
        check("run_start_count", 128'(blk_sent), 128'd4);
        wait_done(100);

        // Reset mid-message, then a fresh message
        lat = 3;
        begin_msg(128'hC0, 5, 5'd16, 128'h2468_ACE0_2468_ACE0_2468_ACE0_2468_ACE0, 1'b1);
        feed(2, 40);
        repeat (2) step(acc_main);
        do_reset();
        begin_msg(128'hD000_0000_0000_0000_0000_0000_0000_0003, 2, 5'd12,
                  128'h8899_AABB_CCDD_EEFF_0011_2233_4455_6677, 1'b1);
        feed(2, 60);
        check("post_rst_count", 128'(blk_sent), 128'd2);
        wait_done(100);
        check("post_rst_err", bit128(err), bit128(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
